// File: rtl/syn_current_accum_if.sv
// ---------------------------------------------------------------------------
// syn_current_accum_if
//   Shared 6-bank synaptic weight BRAM port. All banks see the same address,
//   so the six 64-bit bank read words together form one 384-bit weight word.
//
//   d_r    : write data, one 64-bit lane per bank
//   addr_r : six 9-bit bank addresses
//   ce_r   : per-bank clock enable
//   we_r   : per-bank write enable
//   q_r    : read data, one 64-bit lane per bank (bank b at [64b+63:64b])
//
//   master : the block that issues reads (syn_current_accum)
//   slave  : the BRAM
// ---------------------------------------------------------------------------
interface syn_current_accum_if #(
    parameter int N_BANK = 6,
    parameter int ADDR_W = 9,
    parameter int WORD_W = 384
);
    logic [WORD_W-1:0]        d_r;
    logic [N_BANK*ADDR_W-1:0] addr_r;
    logic [N_BANK-1:0]        ce_r;
    logic [N_BANK-1:0]        we_r;
    logic [WORD_W-1:0]        q_r;

    modport master (
        output d_r, addr_r, ce_r, we_r,
        input  q_r
    );

    modport slave (
        input  d_r, addr_r, ce_r, we_r,
        output q_r
    );
endinterface

// File: rtl/syn_current_accum.sv
// ---------------------------------------------------------------------------
// syn_current_accum
//   Forward-path reader of the synaptic weight BRAM. A start pulse snapshots
//   the presynaptic spike vector, then every weight word (neuron-major, one
//   row of 24 weights per word) is read once. Each word is masked by the
//   matching 24 snapshot bits, summed, and accumulated per neuron; after the
//   neuron's last row the total is written to its slot of o_i_syn.
//
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_run        : start pulse, honoured only when idle
//   i_pre_spike  : presynaptic spikes, bit r*24+c pairs with row r, column c
//   bram         : BRAM read port (master side)
//   o_i_syn      : 18 x 26-bit currents, neuron n at [26n+25:26n]
//   o_nrn_valid  : one-cycle pulse when a neuron's current is written
//   o_nrn_idx    : index of the neuron written with o_nrn_valid
//   o_done       : one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module syn_current_accum #(
    parameter int N_NRN = 18,
    parameter int N_ROW = 24,
    parameter int N_COL = 24,
    parameter int W_W   = 16,
    parameter int ACC_W = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_run,
    input  logic [N_ROW*N_COL-1:0] i_pre_spike,
    syn_current_accum_if.master    bram,
    output logic [N_NRN*ACC_W-1:0] o_i_syn,
    output logic                   o_nrn_valid,
    output logic [4:0]             o_nrn_idx,
    output logic                   o_done
);

    localparam int N_IN      = N_ROW * N_COL;
    localparam int N_WORD    = N_NRN * N_ROW;
    localparam int N_BANK    = 6;
    localparam int ADDR_W    = $clog2(N_WORD);
    localparam int ROW_W     = $clog2(N_ROW);
    localparam int NRN_W     = 5;
    localparam int WORD_W    = N_COL * W_W;
    localparam int SUM_W     = W_W + $clog2(N_COL);
    localparam int DRAIN_CYC = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Row/neuron tag that travels alongside the data through the read
    // pipeline so the accumulate stage knows where each sum belongs.
    typedef struct packed {
        logic             vld;
        logic [NRN_W-1:0] nrn;
        logic [ROW_W-1:0] row;
    } tag_t;

    state_t            state;
    logic [N_IN-1:0]   snap;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [NRN_W-1:0]  nrn_cnt;
    logic [1:0]        drain_cnt;

    tag_t              tag_rd;    // word is on q_r
    tag_t              tag_msk;   // word is in masked_q
    tag_t              tag_sum;   // row sum is in sum_q
    logic [WORD_W-1:0] masked_d;
    logic [WORD_W-1:0] masked_q;
    logic [SUM_W-1:0]  sum_d;
    logic [SUM_W-1:0]  sum_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum_ext;

    // Read-only port: the shared BRAM is written by the STDP block.
    assign bram.d_r    = '0;
    assign bram.we_r   = '0;
    assign bram.ce_r   = {N_BANK{state == S_RUN}};
    assign bram.addr_r = {N_BANK{addr_cnt}};

    // ------------------------------------------------------------------
    // Control FSM: address sweep, drain of the 4-stage read pipeline,
    // and the end-of-pass pulse.
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            snap      <= '0;
            addr_cnt  <= '0;
            row_cnt   <= '0;
            nrn_cnt   <= '0;
            drain_cnt <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        state    <= S_RUN;
                        snap     <= i_pre_spike;
                        addr_cnt <= '0;
                        row_cnt  <= '0;
                        nrn_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (addr_cnt == ADDR_W'(N_WORD - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (row_cnt == ROW_W'(N_ROW - 1)) begin
                            row_cnt <= '0;
                            nrn_cnt <= nrn_cnt + 1'b1;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last word still needs read, mask and sum stages; the
                    // done pulse lines up with the last neuron write.
                    if (drain_cnt == 2'(DRAIN_CYC - 1)) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mask stage input: keep weight c only where the snapshot bit for
    // (row, c) is set.
    // ------------------------------------------------------------------
    // NOTE: combinational outputs get a default before any conditional
    // logic so no path leaves them unassigned (no inferred latches).
    always_comb begin
        masked_d = '0;
        for (int c = 0; c < N_COL; c++) begin
            if (snap[int'(tag_rd.row) * N_COL + c]) begin
                masked_d[c*W_W +: W_W] = bram.q_r[c*W_W +: W_W];
            end
        end
    end

    // Row sum of 24 masked weights; written as a chain, balanced into a
    // tree by synthesis. 24 x 65535 fits in 21 bits.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < N_COL; c++) begin
            sum_d = sum_d + SUM_W'(masked_q[c*W_W +: W_W]);
        end
    end

    assign sum_ext = ACC_W'(sum_q);

    // ------------------------------------------------------------------
    // Read pipeline: tag/read -> mask -> sum -> accumulate/write-out.
    // ------------------------------------------------------------------
    // NOTE: the data-path registers are reset along with the control state
    // so a mid-pass reset cannot leave a partial sum to leak into a later pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd      <= '0;
            tag_msk     <= '0;
            tag_sum     <= '0;
            masked_q    <= '0;
            sum_q       <= '0;
            acc         <= '0;
            o_i_syn     <= '0;
            o_nrn_valid <= 1'b0;
            o_nrn_idx   <= '0;
        end else begin
            tag_rd.vld  <= (state == S_RUN);
            tag_rd.nrn  <= nrn_cnt;
            tag_rd.row  <= row_cnt;
            tag_msk     <= tag_rd;
            tag_sum     <= tag_msk;
            masked_q    <= masked_d;
            sum_q       <= sum_d;
            o_nrn_valid <= 1'b0;

            if (tag_sum.vld) begin
                if (tag_sum.row == ROW_W'(N_ROW - 1)) begin
                    o_i_syn[int'(tag_sum.nrn) * ACC_W +: ACC_W] <= acc + sum_ext;
                    o_nrn_valid <= 1'b1;
                    o_nrn_idx   <= tag_sum.nrn;
                    acc         <= '0;
                end else if (tag_sum.row == '0) begin
                    acc <= sum_ext;
                end else begin
                    acc <= acc + sum_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_syn_current_accum.sv
// ---------------------------------------------------------------------------
// tb_syn_current_accum
//   Self-checking bench for syn_current_accum. A behavioural BRAM (one-edge
//   read latency) holds the weights; the expected current of each neuron is
//   the plain sum of its weights whose spike bit is set in the snapshot.
//   Each pass checks the address sweep, the timing and order of every
//   o_nrn_valid pulse, the o_done timing, output hold between passes, and
//   the final currents.
// ---------------------------------------------------------------------------
module tb_syn_current_accum;

    localparam int N_NRN  = 18;
    localparam int N_ROW  = 24;
    localparam int N_COL  = 24;
    localparam int W_W    = 16;
    localparam int ACC_W  = 26;
    localparam int N_WORD = N_NRN * N_ROW;
    localparam int N_IN   = N_ROW * N_COL;
    localparam int LAST_T = 436;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_run;
    logic [N_IN-1:0]        i_pre_spike;
    logic [N_NRN*ACC_W-1:0] o_i_syn;
    logic                   o_nrn_valid;
    logic [4:0]             o_nrn_idx;
    logic                   o_done;

    logic [383:0] mem [N_WORD];
    logic [25:0]  prev_cur [N_NRN];

    int n_checks = 0;
    int n_fail   = 0;

    syn_current_accum_if bus ();

    syn_current_accum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (i_run),
        .i_pre_spike (i_pre_spike),
        .bram        (bus),
        .o_i_syn     (o_i_syn),
        .o_nrn_valid (o_nrn_valid),
        .o_nrn_idx   (o_nrn_idx),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: data for the address presented before an edge
    // appears after that edge.
    always @(posedge clk) begin
        if (bus.ce_r[0]) bus.q_r <= mem[bus.addr_r[8:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] rand_word();
        logic [383:0] w;
        for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [N_IN-1:0] rand_spikes();
        logic [N_IN-1:0] s;
        for (int i = 0; i < 18; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // Reference: sum of neuron n's weights whose presynaptic input spiked.
    function automatic logic [25:0] model_current(input int n, input logic [N_IN-1:0] sp);
        longint total = 0;
        for (int r = 0; r < N_ROW; r++) begin
            for (int c = 0; c < N_COL; c++) begin
                if (sp[r*N_COL + c]) total += longint'(mem[n*N_ROW + r][c*W_W +: W_W]);
            end
        end
        return total[25:0];
    endfunction

    function automatic logic [25:0] dut_current(input int n);
        return o_i_syn[n*ACC_W +: ACC_W];
    endfunction

    // Called on a falling edge with the DUT idle; returns on the falling
    // edge after E436 (or after a reset recovery when abort_at >= 0), so
    // consecutive calls exercise minimum-period back-to-back passes.
    task automatic run_pass(input string name, input logic [N_IN-1:0] sp,
                            input int repulse_at, input logic [N_IN-1:0] alt_sp,
                            input int abort_at);
        logic [25:0] exp_cur [N_NRN];
        int exp_idx  = 0;
        int done_cnt = 0;
        int done_t   = -1;
        int addr_err = 0;
        int extra    = 0;

        for (int n = 0; n < N_NRN; n++) exp_cur[n] = model_current(n, sp);

        i_run       = 1'b1;
        i_pre_spike = sp;
        @(posedge clk);          // E0
        @(negedge clk);
        i_run       = 1'b0;
        i_pre_spike = ~sp;       // snapshot, not the live input, must be used

        for (int t = 0; t <= LAST_T; t++) begin
            if (t > 0) @(negedge clk);

            if (t <= N_WORD - 1) begin
                if (bus.ce_r !== 6'h3F) addr_err++;
                for (int b = 0; b < 6; b++)
                    if (bus.addr_r[b*9 +: 9] !== 9'(t)) addr_err++;
            end else if (bus.ce_r !== 6'h00) begin
                addr_err++;
            end
            if (bus.we_r !== 6'h00 || bus.d_r !== '0) addr_err++;

            if (o_nrn_valid) begin
                check({name, ":nrn_idx"}, 64'(o_nrn_idx), 64'(exp_idx));
                check({name, ":valid_time"}, 64'(t), 64'(24*exp_idx + 27));
                exp_idx++;
            end
            if (o_done) begin
                done_cnt++;
                done_t = t;
            end

            if (t == 12) begin
                for (int n = 0; n < N_NRN; n++)
                    check({name, ":hold"}, 64'(dut_current(n)), 64'(prev_cur[n]));
            end

            if (t == repulse_at) begin
                i_run       = 1'b1;
                i_pre_spike = alt_sp;
            end
            if (t == repulse_at + 1) i_run = 1'b0;

            if (t == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check({name, ":rst_syn_any"}, 64'(|o_i_syn), 64'd0);
                check({name, ":rst_valid"}, 64'(o_nrn_valid), 64'd0);
                check({name, ":rst_idx"}, 64'(o_nrn_idx), 64'd0);
                check({name, ":rst_done"}, 64'(o_done), 64'd0);
                check({name, ":rst_ce"}, 64'(bus.ce_r), 64'd0);
                check({name, ":addr_before_abort"}, 64'(addr_err), 64'd0);
                repeat (3) @(negedge clk);
                rst_n    = 1'b1;
                done_cnt = 0;
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (o_done) done_cnt++;
                    if (o_nrn_valid || bus.ce_r !== 6'h00) extra++;
                end
                check({name, ":abort_no_done"}, 64'(done_cnt), 64'd0);
                check({name, ":abort_stays_idle"}, 64'(extra), 64'd0);
                for (int n = 0; n < N_NRN; n++) prev_cur[n] = '0;
                return;
            end
        end

        check({name, ":addr_sweep"}, 64'(addr_err), 64'd0);
        check({name, ":valid_count"}, 64'(exp_idx), 64'(N_NRN));
        check({name, ":done_count"}, 64'(done_cnt), 64'd1);
        check({name, ":done_time"}, 64'(done_t), 64'd435);
        for (int n = 0; n < N_NRN; n++) begin
            check({name, ":i_syn"}, 64'(dut_current(n)), 64'(exp_cur[n]));
            prev_cur[n] = exp_cur[n];
        end
    endtask

    initial begin
        logic [N_IN-1:0] sp;
        logic [N_IN-1:0] alt;

        rst_n       = 1'b0;
        i_run       = 1'b0;
        i_pre_spike = '0;
        for (int k = 0; k < N_WORD; k++) mem[k] = '0;
        for (int n = 0; n < N_NRN; n++) prev_cur[n] = '0;
        repeat (3) @(negedge clk);

        check("reset:i_syn_any", 64'(|o_i_syn), 64'd0);
        check("reset:valid", 64'(o_nrn_valid), 64'd0);
        check("reset:idx", 64'(o_nrn_idx), 64'd0);
        check("reset:done", 64'(o_done), 64'd0);
        check("reset:ce", 64'(bus.ce_r), 64'd0);
        check("reset:we", 64'(bus.we_r), 64'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Random weights, no spikes: every current is zero.
        for (int k = 0; k < N_WORD; k++) mem[k] = rand_word();
        run_pass("zero_spk", '0, -1, '0, -1);

        // Single weight in word 0, column 0, with spike bit 0.
        for (int k = 0; k < N_WORD; k++) mem[k] = '0;
        mem[0][15:0] = 16'h1234;
        sp = '0;
        sp[0] = 1'b1;
        run_pass("single", sp, -1, '0, -1);
        check("single:n0_const", 64'(dut_current(0)), 64'h1234);

        // Full scale: no wrap in the 26-bit accumulator.
        for (int k = 0; k < N_WORD; k++) mem[k] = '1;
        run_pass("full", '1, -1, '0, -1);
        check("full:n17_const", 64'(dut_current(17)), 64'd37748160);

        // Neuron 1, row 22, column 5 only (spike bit 533).
        for (int k = 0; k < N_WORD; k++) mem[k] = '0;
        mem[46][5*16 +: 16] = 16'h0001;
        sp = '0;
        sp[533] = 1'b1;
        run_pass("n1_r22", sp, -1, '0, -1);
        check("n1_r22:n1_const", 64'(dut_current(1)), 64'd1);

        // Busy re-pulse with a different vector must be ignored.
        for (int k = 0; k < N_WORD; k++) mem[k] = rand_word();
        sp  = rand_spikes();
        alt = rand_spikes();
        run_pass("repulse", sp, 100, alt, -1);

        // Mid-pass reset, then a clean full pass.
        for (int k = 0; k < N_WORD; k++) mem[k] = rand_word();
        run_pass("abort", rand_spikes(), -1, '0, 200);
        for (int k = 0; k < N_WORD; k++) mem[k] = rand_word();
        run_pass("after_abort", rand_spikes(), -1, '0, -1);

        // Sparse random spikes, back-to-back with the previous pass.
        sp = rand_spikes() & rand_spikes() & rand_spikes();
        run_pass("sparse", sp, -1, '0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_current_accum.md
Name: syn_current_accum

Overview:
- Forward-path reader of the synaptic weight BRAM that the STDP update block writes.
- On each `i_run`, it snapshots the 576-bit presynaptic spike vector.
- It streams all 432 weight words (18 neurons x 24 rows x 24 columns of 16-bit weights) through the shared 6-bank BRAM read interface.
- It produces an unsigned synaptic input current per postsynaptic neuron, which the neuron/membrane-update stage consumes.

Parameters:
- N_NRN, 18, number of postsynaptic neurons.
- N_ROW, 24, BRAM words per neuron.
- N_COL, 24, 16-bit weights per BRAM word.
- W_W, 16, weight width (unsigned).
- ACC_W, 26, accumulator/output width. 576 x 65535 < 2^26, so the accumulator never overflows.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_run  in  1  single-cycle start pulse; ignored unless the FSM is in S_IDLE.
- i_pre_spike  in  576  presynaptic spikes; bit r*24+c pairs with row r, column c of every neuron.
- d_r  out  384  BRAM write data; constant 0.
- addr_r  out  54  six 9-bit bank addresses, all equal to the read address.
- ce_r  out  6  bank enables, all equal to s_run.
- we_r  out  6  constant 0.
- q_r  in  384  BRAM read data; bank b drives bits [64b+63:64b]; weight c is bits [16c+15:16c].
- o_i_syn  out  468  18 x 26-bit currents; neuron n occupies [26n+25:26n].
- o_nrn_valid  out  1  one-cycle pulse when a neuron's current is written.
- o_nrn_idx  out  5  index of the neuron written with o_nrn_valid.
- o_done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low. Reset clears all of the following to 0 and the FSM to S_IDLE:
  - o_i_syn, o_nrn_valid, o_nrn_idx, o_done
  - spike snapshot, address counter, all pipeline registers, accumulator
- FSM states:
  - S_IDLE -> S_RUN on i_run; i_pre_spike is latched into the snapshot on the same edge.
  - S_RUN -> S_DRAIN when the address counter is 431.
  - S_DRAIN -> S_DONE after 3 cycles.
  - S_DONE -> S_IDLE after 1 cycle.
- Busy behaviour: i_run outside S_IDLE is ignored; the snapshot is not updated.
- Addressing: in S_RUN, addr = neuron*24 + row, counting 0..431 one per cycle. Edge E0 samples i_run; address k is driven in the cycle after edge E_k.
- BRAM latency: q_r for address k is valid in the cycle after E_{k+1}.
- Pipeline, for address k = neuron n, row r, tracked by a delayed row/neuron tag shift register:
  - E_{k+2}, mask stage: weight c is zeroed unless snapshot bit r*24+c is set.
  - E_{k+3}, sum stage: 24-input unsigned adder tree, registered, 21 bits.
  - E_{k+4}, accumulate stage:
    - r = 0: acc <= sum.
    - 1 <= r <= 22: acc <= acc + sum.
    - r = 23: o_i_syn[n] <= acc + sum, o_nrn_valid = 1 and o_nrn_idx = n in the following cycle, and acc <= 0.
- Pass completion:
  - Neuron n's output updates at E_{24n+27}; neuron 17 updates at E_435.
  - o_done is high for exactly the cycle after E_435, coincident with the last o_nrn_valid.
- Output hold: o_i_syn entries hold their values between passes and are overwritten neuron by neuron; there is no clear at pass start.
- Reset mid-pass: the pass is abandoned and no o_done is produced. After release, the block waits for a new i_run.
- Back-to-back passes: i_run is accepted in the first S_IDLE cycle after S_DONE, which gives a minimum pass period of 437 cycles.

Test Plan:
- All BRAM words random, i_pre_spike = 0 -> all 18 o_i_syn = 0, 18 o_nrn_valid pulses with idx 0..17, o_done 435 edges after the i_run edge.
- Word 0 = 0x1234 in column 0, all other words 0, i_pre_spike bit 0 set -> o_i_syn[0] = 0x1234, all others 0.
- All weights 0xFFFF, i_pre_spike all ones -> every o_i_syn = 37,748,160 (0x23FFDC0); no wrap.
- Word 46 (neuron 1, row 22) = 0x0001 in column 5, i_pre_spike bit 533 only -> o_i_syn[1] = 1, others 0; address bus checked to sweep 0..431 with ce_r = 6'h3F and we_r = 0.
- i_run re-pulsed at cycle 100 with a different spike vector -> ignored; results match the first snapshot.
- rst_n low at cycle 200 -> all outputs 0 asynchronously, no o_done. A new i_run then gives a correct full pass.
